pipeline_run_ctrl: RTL and testbench
====================================

Name: pipeline_run_ctrl

Overview:
Run-mode sequencer for the 5-stage pipeline. It turns debug-unit commands (run continuous, single step, halt, clear) into the pipeline-wide o_pipeline_mode / o_run_clockcycle controls consumed by every inter-stage latch. It detects end-of-program from the IF/ID EOF flag, drains the remaining stages, requests a latch-data dump after each step and at completion, and counts executed clock cycles. It sits between the UART debug unit and the pipeline latches.

Parameters:
NB_CYCLES, 32, width of executed-cycle counter
DRAIN_CYCLES, 4, executed cycles needed after EOF detection to drain ID..WB
NB_DRAIN, 3, width of drain counter (must hold DRAIN_CYCLES-1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command strobe from debug unit
i_cmd  in  2  00 RUN_CONT, 01 STEP, 10 HALT, 11 CLEAR
i_eof_flag  in  1  EOF flag from IF/ID latch
i_dump_done  in  1  debug unit finished sending latch data (1-cycle pulse)
o_cmd_ack  out  1  1-cycle pulse: command accepted
o_pipeline_mode  out  2  00 frozen, 01 continuous, 11 stepwise
o_run_clockcycle  out  1  1-cycle step-enable pulse
o_pipe_clear  out  1  1-cycle pulse to flush/reset pipeline latches and PC
o_dump_req  out  1  level request to dump latch data
o_done  out  1  program finished, pipeline frozen
o_cycle_count  out  NB_CYCLES  executed cycles since last CLEAR/reset

Behaviour:
- Reset: state IDLE; all outputs 0; o_pipeline_mode=00; counters, eof_seen, finished, step_session cleared.
- All outputs registered or decoded from registered state only; no combinational path from i_cmd to outputs.
- exec = (state==CONT) or (state==STEP_PULSE); exactly the cycles in which latches advance.
- o_cycle_count += 1 on every exec cycle; saturates at all-ones.
- EOF/drain: on exec with i_eof_flag=1 and eof_seen=0 -> eof_seen<=1, drain_cnt<=DRAIN_CYCLES-1. On exec with eof_seen=1: drain_cnt==0 -> finished<=1 (this is the last exec cycle), else drain_cnt-=1. Result: last exec occurs DRAIN_CYCLES exec cycles after the detecting one. EOF is sampled only on exec cycles.
- States:
  IDLE: mode 00. RUN_CONT -> CONT; STEP -> STEP_PULSE (step_session<=1); CLEAR -> CLR; HALT -> ack, stay.
  CONT: mode 01. Finishing exec -> DUMP. HALT -> DUMP (finished<=1). Other cmds ignored (no ack). A HALT arriving on the finishing cycle is absorbed, ack given.
  STEP_PULSE: mode 11, o_run_clockcycle=1, exactly one cycle -> DUMP. Commands ignored.
  DUMP: mode 00 if finished else 11; o_dump_req=1 until i_dump_done. Then finished -> DONE, else -> STEP_WAIT. Commands ignored.
  STEP_WAIT: mode 11, run 0. STEP -> STEP_PULSE; RUN_CONT -> CONT (step_session<=0); HALT -> DONE (finished<=1); CLEAR -> CLR.
  DONE: mode 00, o_done=1. CLEAR -> CLR; all else ignored.
  CLR: o_pipe_clear=1 for one cycle; counters, eof_seen, finished, step_session cleared -> IDLE.
- o_cmd_ack pulses in the cycle after an accepted command; ignored commands produce no ack and no state change.
- i_dump_done outside DUMP: ignored.
- Reset mid-run: returns to IDLE next edge, no dump, no clear pulse.

Decomposition:
- Shared package: command encodings, mode encodings (00/01/11, matching latches), state encoding.
- Sub-module: exec_cycle_counter (saturating NB_CYCLES counter, sync clear, enable=exec).

Test Plan:
- RUN_CONT, eof_flag high on exec #10 -> mode 01 for 14 cycles, dump_req rises, after i_dump_done o_done=1, mode 00, o_cycle_count=14.
- 3x STEP with dump_done each -> three single-cycle run pulses, mode stays 11, count=3, ack per command, in STEP_WAIT.
- STEP, then STEP during DUMP -> second STEP ignored (no ack, no pulse), count=1.
- RUN_CONT, HALT at count 7 -> dump, DONE, count=7; CLEAR -> o_pipe_clear 1 cycle, count=0, IDLE.
- Stepping with EOF at step 2 -> finish on step 6; dump; DONE, mode 00.
- Reset asserted in CONT at count 5 -> next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/pipeline_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_run_ctrl_pkg
//  Description : Shared encodings for the pipeline run-mode sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_run_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_RUN_CONT = 2'b00,
        CMD_STEP     = 2'b01,
        CMD_HALT     = 2'b10,
        CMD_CLEAR    = 2'b11
    } cmd_e;

    // Values match the mode decode inside every inter-stage latch.
    typedef enum logic [1:0] {
        MODE_FROZEN = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_STEP   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CONT       = 3'd1,
        ST_STEP_PULSE = 3'd2,
        ST_DUMP       = 3'd3,
        ST_STEP_WAIT  = 3'd4,
        ST_DONE       = 3'd5,
        ST_CLR        = 3'd6
    } state_e;

    function automatic logic is_exec(input state_e s);
        return (s == ST_CONT) || (s == ST_STEP_PULSE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_exec_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_run_ctrl_exec_cycle_counter
//  Description : Saturating executed-cycle counter with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_ctrl_exec_cycle_counter #(
    parameter int NB_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    output logic [NB_CYCLES-1:0] o_count
);

    logic [NB_CYCLES-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + NB_CYCLES'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_run_ctrl
//  Description : Run-mode sequencer turning debug commands into pipeline
//                latch controls, with EOF drain, dump requests and cycle count.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
#(
    parameter int NB_CYCLES    = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_DRAIN     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    input  logic                 i_eof_flag,
    input  logic                 i_dump_done,
    output logic                 o_cmd_ack,
    output logic [1:0]           o_pipeline_mode,
    output logic                 o_run_clockcycle,
    output logic                 o_pipe_clear,
    output logic                 o_dump_req,
    output logic                 o_done,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    localparam logic [NB_DRAIN-1:0] c_drain_init = NB_DRAIN'(DRAIN_CYCLES - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic                r_cmd_ack;
    logic                r_eof_seen;
    logic                r_finished;
    logic                r_step_session;
    logic [NB_DRAIN-1:0] r_drain_cnt;

    logic                w_exec;
    logic                w_finishing;
    logic                w_accept;
    logic                w_halt_finish;
    logic                w_session_set;
    logic                w_session_clr;
    cmd_e                w_cmd;
    mode_e               w_mode;

    assign w_cmd       = cmd_e'(i_cmd);
    assign w_exec      = is_exec(r_state);
    // Last exec cycle of the program: drain already counted down to zero.
    assign w_finishing = w_exec && r_eof_seen && (r_drain_cnt == '0);

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_halt_finish = 1'b0;
        w_session_set = 1'b0;
        w_session_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    case (w_cmd)
                        CMD_RUN_CONT: w_next_state = ST_CONT;
                        CMD_STEP: begin
                            w_next_state  = ST_STEP_PULSE;
                            w_session_set = 1'b1;
                        end
                        CMD_CLEAR:    w_next_state = ST_CLR;
                        CMD_HALT:     w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_CONT: begin
                if (w_finishing) begin
                    w_next_state = ST_DUMP;
                end
                if (i_cmd_valid && (w_cmd == CMD_HALT)) begin
                    w_accept      = 1'b1;
                    w_halt_finish = 1'b1;
                    w_next_state  = ST_DUMP;
                end
            end
            ST_STEP_PULSE: w_next_state = ST_DUMP;
            ST_DUMP: begin
                if (i_dump_done) begin
                    w_next_state = (r_finished || !r_step_session) ? ST_DONE : ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    case (w_cmd)
                        CMD_STEP:     w_next_state = ST_STEP_PULSE;
                        CMD_RUN_CONT: begin
                            w_next_state  = ST_CONT;
                            w_session_clr = 1'b1;
                        end
                        CMD_HALT: begin
                            w_next_state  = ST_DONE;
                            w_halt_finish = 1'b1;
                        end
                        CMD_CLEAR:    w_next_state = ST_CLR;
                    endcase
                end
            end
            ST_DONE: begin
                if (i_cmd_valid && (w_cmd == CMD_CLEAR)) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_CLR;
                end
            end
            ST_CLR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_cmd_ack      <= 1'b0;
            r_eof_seen     <= 1'b0;
            r_finished     <= 1'b0;
            r_step_session <= 1'b0;
            r_drain_cnt    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cmd_ack <= w_accept;
            if (r_state == ST_CLR) begin
                r_eof_seen     <= 1'b0;
                r_finished     <= 1'b0;
                r_step_session <= 1'b0;
                r_drain_cnt    <= '0;
            end else begin
                // EOF is only meaningful while the latches actually advance.
                if (w_exec) begin
                    if (!r_eof_seen) begin
                        if (i_eof_flag) begin
                            r_eof_seen  <= 1'b1;
                            r_drain_cnt <= c_drain_init;
                        end
                    end else if (r_drain_cnt == '0) begin
                        r_finished <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - NB_DRAIN'(1);
                    end
                end
                if (w_halt_finish) begin
                    r_finished <= 1'b1;
                end
                if (w_session_set) begin
                    r_step_session <= 1'b1;
                end else if (w_session_clr) begin
                    r_step_session <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_mode = MODE_FROZEN;
        case (r_state)
            ST_CONT:       w_mode = MODE_CONT;
            ST_STEP_PULSE: w_mode = MODE_STEP;
            ST_STEP_WAIT:  w_mode = MODE_STEP;
            ST_DUMP:       w_mode = r_finished ? MODE_FROZEN : MODE_STEP;
            default:       w_mode = MODE_FROZEN;
        endcase
    end

    assign o_pipeline_mode  = w_mode;
    assign o_cmd_ack        = r_cmd_ack;
    assign o_run_clockcycle = (r_state == ST_STEP_PULSE);
    assign o_pipe_clear     = (r_state == ST_CLR);
    assign o_dump_req       = (r_state == ST_DUMP);
    assign o_done           = (r_state == ST_DONE);

    pipeline_run_ctrl_exec_cycle_counter #(
        .NB_CYCLES (NB_CYCLES)
    ) u_exec_cycle_counter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (r_state == ST_CLR),
        .i_enable (w_exec),
        .o_count  (o_cycle_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_run_ctrl
//  Description : Directed self-checking bench for pipeline_run_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_run_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd = 2'b00;
    logic        i_eof_flag = 1'b0;
    logic        i_dump_done = 1'b0;
    logic        o_cmd_ack;
    logic [1:0]  o_pipeline_mode;
    logic        o_run_clockcycle;
    logic        o_pipe_clear;
    logic        o_dump_req;
    logic        o_done;
    logic [31:0] o_cycle_count;

    int errors = 0;
    int checks = 0;

    pipeline_run_ctrl dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_cmd_valid      (i_cmd_valid),
        .i_cmd            (i_cmd),
        .i_eof_flag       (i_eof_flag),
        .i_dump_done      (i_dump_done),
        .o_cmd_ack        (o_cmd_ack),
        .o_pipeline_mode  (o_pipeline_mode),
        .o_run_clockcycle (o_run_clockcycle),
        .o_pipe_clear     (o_pipe_clear),
        .o_dump_req       (o_dump_req),
        .o_done           (o_done),
        .o_cycle_count    (o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic send_cmd(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic pulse_dump_done();
        i_dump_done = 1'b1;
        tick();
        i_dump_done = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        checks++;
        if ({o_cmd_ack, o_run_clockcycle, o_pipe_clear, o_dump_req, o_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {o_cmd_ack, o_run_clockcycle, o_pipe_clear, o_dump_req, o_done});
        end
        checks++;
        if (o_pipeline_mode !== 2'b00) begin
            errors++; $display("FAIL reset_mode: got %b expected 00", o_pipeline_mode);
        end
        checks++;
        if (o_cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", o_cycle_count);
        end
        // HALT in IDLE is acknowledged but changes nothing
        send_cmd(2'b10);
        checks++;
        if ({o_cmd_ack, o_pipeline_mode, o_done} !== 4'b1000) begin
            errors++; $display("FAIL idle_halt: got %b expected 1000", {o_cmd_ack, o_pipeline_mode, o_done});
        end
    endtask

    task automatic do_clear(input string name);
        send_cmd(2'b11);
        checks++;
        if ({o_pipe_clear, o_cmd_ack} !== 2'b11) begin
            errors++; $display("FAIL %s_clear_pulse: got %b expected 11", name, {o_pipe_clear, o_cmd_ack});
        end
        tick();
        checks++;
        if ({o_pipe_clear, o_pipeline_mode, o_done, o_cycle_count} !== {1'b0, 2'b00, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL %s_after_clear: got clr=%b mode=%b done=%b count=%0d expected 0 00 0 0",
                     name, o_pipe_clear, o_pipeline_mode, o_done, o_cycle_count);
        end
    endtask

    task automatic test_run_cont_eof();
        int n;
        n = 0;
        send_cmd(2'b00);
        checks++;
        if ({o_cmd_ack, o_pipeline_mode} !== 3'b101) begin
            errors++; $display("FAIL cont_start: got %b expected 101", {o_cmd_ack, o_pipeline_mode});
        end
        for (int k = 0; k < 40 && o_pipeline_mode == 2'b01; k++) begin
            n++;
            if (o_cycle_count == 32'd9) i_eof_flag = 1'b1;
            tick();
        end
        checks++;
        if (n !== 14) begin
            errors++; $display("FAIL cont_mode_cycles: got %0d expected 14", n);
        end
        checks++;
        if ({o_dump_req, o_pipeline_mode, o_done, o_cycle_count} !== {1'b1, 2'b00, 1'b0, 32'd14}) begin
            errors++;
            $display("FAIL cont_dump: got req=%b mode=%b done=%b count=%0d expected 1 00 0 14",
                     o_dump_req, o_pipeline_mode, o_done, o_cycle_count);
        end
        i_eof_flag = 1'b0;
        pulse_dump_done();
        checks++;
        if ({o_done, o_dump_req, o_pipeline_mode, o_cycle_count} !== {1'b1, 1'b0, 2'b00, 32'd14}) begin
            errors++;
            $display("FAIL cont_done: got done=%b req=%b mode=%b count=%0d expected 1 0 00 14",
                     o_done, o_dump_req, o_pipeline_mode, o_cycle_count);
        end
        // RUN_CONT in DONE is ignored
        send_cmd(2'b00);
        checks++;
        if ({o_cmd_ack, o_done} !== 2'b01) begin
            errors++; $display("FAIL done_ignore: got %b expected 01", {o_cmd_ack, o_done});
        end
        do_clear("cont");
    endtask

    task automatic test_steps();
        int pulses;
        pulses = 0;
        for (int s = 1; s <= 3; s++) begin
            send_cmd(2'b01);
            if (o_run_clockcycle === 1'b1) pulses++;
            checks++;
            if ({o_cmd_ack, o_run_clockcycle, o_pipeline_mode} !== 4'b1111) begin
                errors++; $display("FAIL step%0d_pulse: got %b expected 1111", s,
                                   {o_cmd_ack, o_run_clockcycle, o_pipeline_mode});
            end
            tick();
            if (o_run_clockcycle === 1'b1) pulses++;
            checks++;
            if ({o_dump_req, o_run_clockcycle, o_pipeline_mode} !== 4'b1011) begin
                errors++; $display("FAIL step%0d_dump: got %b expected 1011", s,
                                   {o_dump_req, o_run_clockcycle, o_pipeline_mode});
            end
            pulse_dump_done();
        end
        checks++;
        if ({o_dump_req, o_pipeline_mode, o_done, o_cycle_count} !== {1'b0, 2'b11, 1'b0, 32'd3}) begin
            errors++;
            $display("FAIL steps_wait: got req=%b mode=%b done=%b count=%0d expected 0 11 0 3",
                     o_dump_req, o_pipeline_mode, o_done, o_cycle_count);
        end
        checks++;
        if (pulses !== 3) begin
            errors++; $display("FAIL steps_pulses: got %0d expected 3", pulses);
        end
        do_clear("steps");
    endtask

    task automatic test_step_during_dump();
        send_cmd(2'b01);
        tick();
        send_cmd(2'b01);
        checks++;
        if ({o_cmd_ack, o_run_clockcycle, o_dump_req, o_cycle_count} !== {1'b0, 1'b0, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL dump_step_ignored: got ack=%b run=%b req=%b count=%0d expected 0 0 1 1",
                     o_cmd_ack, o_run_clockcycle, o_dump_req, o_cycle_count);
        end
        pulse_dump_done();
        checks++;
        if ({o_pipeline_mode, o_dump_req, o_cycle_count} !== {2'b11, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL dump_step_wait: got mode=%b req=%b count=%0d expected 11 0 1",
                     o_pipeline_mode, o_dump_req, o_cycle_count);
        end
        do_clear("dumpstep");
    endtask

    task automatic test_halt();
        send_cmd(2'b00);
        for (int k = 0; k < 40 && o_cycle_count != 32'd6; k++) tick();
        send_cmd(2'b10);
        checks++;
        if ({o_cmd_ack, o_dump_req, o_pipeline_mode, o_cycle_count} !== {1'b1, 1'b1, 2'b00, 32'd7}) begin
            errors++;
            $display("FAIL halt_dump: got ack=%b req=%b mode=%b count=%0d expected 1 1 00 7",
                     o_cmd_ack, o_dump_req, o_pipeline_mode, o_cycle_count);
        end
        pulse_dump_done();
        checks++;
        if ({o_done, o_cycle_count} !== {1'b1, 32'd7}) begin
            errors++; $display("FAIL halt_done: got done=%b count=%0d expected 1 7", o_done, o_cycle_count);
        end
        do_clear("halt");
    endtask

    task automatic test_step_eof();
        for (int s = 1; s <= 6; s++) begin
            i_eof_flag = (s >= 2);
            send_cmd(2'b01);
            tick();
            checks++;
            if (o_pipeline_mode !== ((s == 6) ? 2'b00 : 2'b11)) begin
                errors++; $display("FAIL stepeof%0d_dump_mode: got %b expected %b", s,
                                   o_pipeline_mode, (s == 6) ? 2'b00 : 2'b11);
            end
            pulse_dump_done();
            checks++;
            if (o_done !== (s == 6)) begin
                errors++; $display("FAIL stepeof%0d_done: got %b expected %b", s, o_done, s == 6);
            end
        end
        i_eof_flag = 1'b0;
        checks++;
        if ({o_pipeline_mode, o_cycle_count} !== {2'b00, 32'd6}) begin
            errors++; $display("FAIL stepeof_final: got mode=%b count=%0d expected 00 6",
                               o_pipeline_mode, o_cycle_count);
        end
        do_clear("stepeof");
    endtask

    task automatic test_reset_mid_run();
        send_cmd(2'b00);
        for (int k = 0; k < 40 && o_cycle_count != 32'd5; k++) tick();
        checks++;
        if ({o_pipeline_mode, o_cycle_count} !== {2'b01, 32'd5}) begin
            errors++; $display("FAIL midrst_pre: got mode=%b count=%0d expected 01 5",
                               o_pipeline_mode, o_cycle_count);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checks++;
        if ({o_cmd_ack, o_pipeline_mode, o_run_clockcycle, o_pipe_clear, o_dump_req, o_done, o_cycle_count}
            !== {7'b0, 32'd0}) begin
            errors++;
            $display("FAIL midrst_outputs: got ack=%b mode=%b run=%b clr=%b req=%b done=%b count=%0d expected all 0",
                     o_cmd_ack, o_pipeline_mode, o_run_clockcycle, o_pipe_clear, o_dump_req, o_done, o_cycle_count);
        end
        tick();
        checks++;
        if ({o_pipeline_mode, o_pipe_clear, o_dump_req, o_cycle_count} !== {4'b0, 32'd0}) begin
            errors++;
            $display("FAIL midrst_idle: got mode=%b clr=%b req=%b count=%0d expected 00 0 0 0",
                     o_pipeline_mode, o_pipe_clear, o_dump_req, o_cycle_count);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_run_cont_eof();
        test_steps();
        test_step_during_dump();
        test_halt();
        test_step_eof();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
